// File: rtl/faims_sweep_ctrl.sv
// Sweep sequencer for the FAIMS drive: soft-start ramp, stepped dwell sweep, soft-stop.
// Parameter updates to the FAIMS block land only on period boundaries.
module faims_sweep_ctrl #(
  parameter int PERIOD_W = 10,
  parameter int WORK_W   = 8,
  parameter int DWELL_W  = 24
) (
  input  logic                CLK,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [PERIOD_W-1:0] i_cfgPeriod,
  input  logic [PERIOD_W-1:0] i_cfgPulseLen,
  input  logic [WORK_W-1:0]   i_workStart,
  input  logic [WORK_W-1:0]   i_workStop,
  input  logic [WORK_W-1:0]   i_workStep,
  input  logic [DWELL_W-1:0]  i_dwell,
  output logic                o_faimsEnable,
  output logic [PERIOD_W-1:0] o_parFaimsPeriod,
  output logic [PERIOD_W-1:0] o_parFaimsPulseLen,
  output logic [WORK_W-1:0]   o_parWork,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_stepTick,
  output logic [7:0]          o_stepIndex,
  output logic                o_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAMP     = 3'd1,
    S_DWELL    = 3'd2,
    S_RAMPDOWN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [PERIOD_W-1:0] period_sh_r;
  logic [PERIOD_W-1:0] pulse_sh_r;
  logic [WORK_W-1:0]   start_sh_r;
  logic [WORK_W-1:0]   stop_sh_r;
  logic [WORK_W-1:0]   step_sh_r;
  logic [DWELL_W-1:0]  dwell_sh_r;

  logic [PERIOD_W-1:0] cnt_r;
  logic [PERIOD_W-1:0] cnt_s;
  logic [DWELL_W-1:0]  dwell_cnt_r;
  logic [DWELL_W-1:0]  dwell_cnt_s;
  logic [WORK_W-1:0]   work_r;
  logic [WORK_W-1:0]   work_s;
  logic [7:0]          step_index_r;
  logic [7:0]          step_index_s;
  logic                enable_r;
  logic                enable_s;
  logic                busy_r;
  logic                busy_s;
  logic                done_r;
  logic                done_s;
  logic                tick_r;
  logic                tick_s;
  logic                err_r;
  logic                err_s;

  logic                cfg_ok_s;
  logic                accept_s;
  logic                active_s;
  logic                bt_s;
  logic                step_done_s;
  logic                over_s;
  logic [WORK_W:0]     next_work_s;
  logic [DWELL_W-1:0]  dwell_eff_s;

  // Pulse must fit twice inside the period so the drive waveform keeps a gap.
  function automatic logic cfg_valid(
    input logic [PERIOD_W-1:0] per,
    input logic [PERIOD_W-1:0] pul,
    input logic [WORK_W-1:0]   ws,
    input logic [WORK_W-1:0]   we,
    input logic [WORK_W-1:0]   wst
  );
    logic [PERIOD_W:0] dbl;
    dbl = {pul, 1'b0};
    cfg_valid = (per >= PERIOD_W'(4)) && (pul != {PERIOD_W{1'b0}}) &&
                (dbl < {1'b0, per}) && (wst != {WORK_W{1'b0}}) && (ws <= we);
  endfunction

  assign cfg_ok_s    = cfg_valid(i_cfgPeriod, i_cfgPulseLen, i_workStart, i_workStop, i_workStep);
  assign accept_s    = (state_r == S_IDLE) && i_start && cfg_ok_s;
  assign active_s    = (state_r == S_RAMP) || (state_r == S_DWELL) || (state_r == S_RAMPDOWN);
  assign bt_s        = active_s && (cnt_r == (period_sh_r - PERIOD_W'(1)));
  assign dwell_eff_s = (dwell_sh_r == {DWELL_W{1'b0}}) ? DWELL_W'(1) : dwell_sh_r;
  assign step_done_s = (state_r == S_DWELL) && bt_s && (dwell_cnt_r >= (dwell_eff_s - DWELL_W'(1)));
  // One extra bit so a step past the top of the range is seen instead of wrapping.
  assign next_work_s = {1'b0, work_r} + {1'b0, step_sh_r};
  assign over_s      = next_work_s > {1'b0, stop_sh_r};

  // State register.
  always_ff @(posedge CLK or posedge i_reset) begin
    if (i_reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = (i_workStart == {WORK_W{1'b0}}) ? S_DWELL : S_RAMP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RAMP: begin
        if (i_abort) begin
          state_s = S_RAMPDOWN;
        end else if (bt_s && ((work_r + WORK_W'(1)) == start_sh_r)) begin
          state_s = S_DWELL;
        end else begin
          state_s = S_RAMP;
        end
      end
      S_DWELL: begin
        if (i_abort) begin
          state_s = S_RAMPDOWN;
        end else if (step_done_s && over_s) begin
          state_s = S_RAMPDOWN;
        end else begin
          state_s = S_DWELL;
        end
      end
      S_RAMPDOWN: begin
        if (work_r == {WORK_W{1'b0}}) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RAMPDOWN;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of counters and registered outputs.
  always_comb begin
    cnt_s        = cnt_r;
    dwell_cnt_s  = dwell_cnt_r;
    work_s       = work_r;
    step_index_s = step_index_r;
    err_s        = err_r;
    case (state_r)
      S_IDLE: begin
        cnt_s       = {PERIOD_W{1'b0}};
        dwell_cnt_s = {DWELL_W{1'b0}};
        work_s      = {WORK_W{1'b0}};
        if (i_start) begin
          err_s = ~cfg_ok_s;
          if (cfg_ok_s) begin
            step_index_s = 8'd0;
          end else begin
            step_index_s = step_index_r;
          end
        end else begin
          err_s = err_r;
        end
      end
      S_RAMP: begin
        cnt_s       = bt_s ? {PERIOD_W{1'b0}} : (cnt_r + PERIOD_W'(1));
        dwell_cnt_s = {DWELL_W{1'b0}};
        if (!i_abort && bt_s) begin
          work_s = work_r + WORK_W'(1);
        end else begin
          work_s = work_r;
        end
      end
      S_DWELL: begin
        cnt_s = bt_s ? {PERIOD_W{1'b0}} : (cnt_r + PERIOD_W'(1));
        if (i_abort) begin
          dwell_cnt_s = dwell_cnt_r;
        end else if (step_done_s) begin
          dwell_cnt_s = {DWELL_W{1'b0}};
          if (!over_s) begin
            work_s       = next_work_s[WORK_W-1:0];
            step_index_s = (step_index_r == 8'd255) ? 8'd255 : (step_index_r + 8'd1);
          end else begin
            work_s = work_r;
          end
        end else if (bt_s) begin
          dwell_cnt_s = dwell_cnt_r + DWELL_W'(1);
        end else begin
          dwell_cnt_s = dwell_cnt_r;
        end
      end
      S_RAMPDOWN: begin
        cnt_s = bt_s ? {PERIOD_W{1'b0}} : (cnt_r + PERIOD_W'(1));
        if (bt_s && (work_r != {WORK_W{1'b0}})) begin
          work_s = work_r - WORK_W'(1);
        end else begin
          work_s = work_r;
        end
      end
      S_DONE: begin
        cnt_s  = {PERIOD_W{1'b0}};
        work_s = {WORK_W{1'b0}};
      end
      default: begin
        cnt_s  = {PERIOD_W{1'b0}};
        work_s = {WORK_W{1'b0}};
      end
    endcase

    enable_s = (state_s == S_RAMP) || (state_s == S_DWELL) || (state_s == S_RAMPDOWN);
    busy_s   = (state_s != S_IDLE);
    done_s   = (state_s == S_DONE);
    // A tick marks every dwell start, both the first entry and each re-entry after a step.
    tick_s   = (state_s == S_DWELL) && ((state_r != S_DWELL) || step_done_s);
  end

  // Datapath, shadow and output registers.
  always_ff @(posedge CLK or posedge i_reset) begin
    if (i_reset) begin
      cnt_r        <= {PERIOD_W{1'b0}};
      dwell_cnt_r  <= {DWELL_W{1'b0}};
      work_r       <= {WORK_W{1'b0}};
      step_index_r <= 8'd0;
      enable_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      tick_r       <= 1'b0;
      err_r        <= 1'b0;
      period_sh_r  <= {PERIOD_W{1'b0}};
      pulse_sh_r   <= {PERIOD_W{1'b0}};
      start_sh_r   <= {WORK_W{1'b0}};
      stop_sh_r    <= {WORK_W{1'b0}};
      step_sh_r    <= {WORK_W{1'b0}};
      dwell_sh_r   <= {DWELL_W{1'b0}};
    end else begin
      cnt_r        <= cnt_s;
      dwell_cnt_r  <= dwell_cnt_s;
      work_r       <= work_s;
      step_index_r <= step_index_s;
      enable_r     <= enable_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      tick_r       <= tick_s;
      err_r        <= err_s;
      if (accept_s) begin
        period_sh_r <= i_cfgPeriod;
        pulse_sh_r  <= i_cfgPulseLen;
        start_sh_r  <= i_workStart;
        stop_sh_r   <= i_workStop;
        step_sh_r   <= i_workStep;
        dwell_sh_r  <= i_dwell;
      end
    end
  end

  assign o_faimsEnable      = enable_r;
  assign o_parFaimsPeriod   = period_sh_r;
  assign o_parFaimsPulseLen = pulse_sh_r;
  assign o_parWork          = work_r;
  assign o_busy             = busy_r;
  assign o_done             = done_r;
  assign o_stepTick         = tick_r;
  assign o_stepIndex        = step_index_r;
  assign o_err              = err_r;

endmodule

// File: doc/faims_sweep_ctrl.md
# faims_sweep_ctrl

Sequencer for the FAIMS drive block. It soft-starts and sweeps the work (current-draw) parameter across a host-programmed range, with a fixed dwell at each step, then soft-stops. It owns the faims enable and parameter inputs, and applies parameter changes only at FAIMS period boundaries. It sits between the host/Raspberry register file and the faims instance, and emits a step tick that the acquisition logic uses to tag samples.

## Interface
Parameters:
- PERIOD_W, 10, width of period/pulse-length fields
- WORK_W, 8, width of work fields
- DWELL_W, 24, width of dwell count (in FAIMS periods)

Ports:
- CLK  in  1  system clock
- i_reset  in  1  reset; one clock, reset is asynchronous and active-high
- i_start  in  1  start sweep (sampled when idle)
- i_abort  in  1  abort: go to ramp-down
- i_cfgPeriod  in  PERIOD_W  FAIMS period in CLK cycles
- i_cfgPulseLen  in  PERIOD_W  FAIMS pulse length
- i_workStart, i_workStop, i_workStep  in  WORK_W  sweep range and increment
- i_dwell  in  DWELL_W  periods per step (0 treated as 1)
- o_faimsEnable  out  1  to faims i_enable
- o_parFaimsPeriod, o_parFaimsPulseLen  out  PERIOD_W  to faims
- o_parWork  out  WORK_W  to faims i_parWork
- o_busy  out  1  sweep in progress
- o_done  out  1  one-cycle completion pulse
- o_stepTick  out  1  one-cycle pulse at each dwell start
- o_stepIndex  out  8  current step number, 0-based
- o_err  out  1  sticky configuration error

## Operation
- States: IDLE, RAMP, DWELL, RAMPDOWN, DONE.
- IDLE: enable=0, work=0. i_start=1 validates the config:
  - period>=4, pulseLen>=1, 2*pulseLen<period
  - step!=0, start<=stop
- Invalid config: o_err=1, stay IDLE. o_err clears on the next accepted start.
- Valid config:
  - latch all cfg inputs into shadow registers; the period/pulse outputs are driven from the shadows
  - clear the period counter, stepIndex=0
  - enable=1, go to RAMP
- Period counter runs 0..period-1 and wraps. A boundary tick (bt) fires when counter==period-1.
- RAMP: work+=1 on each bt. When work==workStart, go to DWELL. If workStart==0, go directly to DWELL.
- DWELL:
  - stepTick pulses on entry; the dwell counter counts bt
  - after max(dwell,1) bt, compute next = work+step in WORK_W+1 bits
  - next>stop: go to RAMPDOWN
  - else: work=next, stepIndex+=1 (saturating at 255), re-enter DWELL with a new stepTick
- RAMPDOWN: work-=1 on each bt until 0, then enable=0 and go to DONE. If already 0, go straight to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- o_busy=1 in RAMP, DWELL, RAMPDOWN, DONE.
- Abort in RAMP/DWELL: go to RAMPDOWN on the next cycle; work holds its current value. Abort in IDLE/RAMPDOWN/DONE is ignored.
- Start and abort in the same IDLE cycle: start wins.
- Start while busy is ignored. Config changes while busy are ignored (shadowed).

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, shadows 0.
- All outputs are registered.
- Start accepted at cycle 0: busy=1 and enable=1 at cycle 1; the period counter is 0 at cycle 1.
- work changes only in the cycle after a bt, so a work change is never mid-period.
- stepTick is asserted in the cycle the DWELL state is first registered.
- Total sweep length in periods = workStart + (number of steps × dwell) + final work. done is asserted 1 cycle after the last decrement.
- Reset asserted mid-sweep:
  - enable, work and busy drop to 0 immediately (asynchronously)
  - no done pulse
  - state returns to IDLE

## Test plan
- Reset check: hold i_reset, then release with no start. All outputs must stay 0 for 1000 cycles.
- Nominal sweep: period=250, pulse=20, start=4, stop=12, step=4, dwell=2.
  - work ramps 1,2,3,4 at 250-cycle spacing
  - stepTick at work 4, 8, 12; stepIndex 0, 1, 2
  - ramp down 12→0
  - done at 22 periods (5500 cycles ±2) after start; enable=0 afterwards
- Bad config: pulse=125 with period=250 → o_err=1, enable stays 0. A following valid start clears o_err.
- Abort during DWELL at work=8: RAMPDOWN decrements 8→0 over 8 periods, then done. No further stepTick.
- Overflow edge: start=250, stop=255, step=10 → a single dwell at 250 (next=260>255), then ramp-down. o_parWork never wraps.
- Reset mid-ramp at work=3: outputs return to 0 within the reset cycle. A new start afterwards runs a clean sweep.
